// File: rtl/dcache_controller.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// Hits resolve combinationally in IDLE; misses sequence write-back then refill over a block port.
module dcache_controller #(
   parameter int SETS        = 8,
   parameter int WAYS        = 2,
   parameter int BLOCK_WORDS = 4,
   parameter int TAG_W       = 32 - $clog2(SETS) - $clog2(BLOCK_WORDS) - 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cpu_read,
   input  logic                                 cpu_write,
   input  logic [31:0]                          cpu_addr,
   input  logic [31:0]                          cpu_wdata,
   output logic [31:0]                          cpu_rdata,
   output logic                                 cpu_busywait,
   output logic                                 mem_read,
   output logic                                 mem_write,
   output logic [32-$clog2(BLOCK_WORDS)-3:0]    mem_addr,
   output logic [32*BLOCK_WORDS-1:0]            mem_wdata,
   input  logic [32*BLOCK_WORDS-1:0]            mem_rdata,
   input  logic                                 mem_busywait
);

   localparam int IW = $clog2(SETS);
   localparam int OW = $clog2(BLOCK_WORDS);
   localparam int BW = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
   logic [BW-1:0]    data_arr [WAYS][SETS];
   logic [WAYS-1:0]  valid_q  [SETS];
   logic [WAYS-1:0]  dirty_q  [SETS];
   logic [SETS-1:0]  lru_q;

   logic             victim_q;
   logic [TAG_W-1:0] req_tag_q;
   logic [IW-1:0]    req_idx_q;

   logic [OW-1:0]    req_word;
   logic [IW-1:0]    req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             req;
   logic [WAYS-1:0]  way_hit;
   logic             hit;
   logic             hit_way;
   logic             victim_d;
   logic             victim_dirty;
   logic [BW-1:0]    hit_block;
   logic [OW+4:0]    word_base;
   logic             unused_addr_bits;

   assign req_word         = cpu_addr[OW+1:2];
   assign req_idx          = cpu_addr[IW+OW+1:OW+2];
   assign req_tag          = cpu_addr[31:IW+OW+2];
   assign unused_addr_bits = ^cpu_addr[1:0];
   assign req              = cpu_read | cpu_write;
   assign word_base        = {req_word, 5'b0};

   always_comb begin
      way_hit = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         way_hit[w] = valid_q[req_idx][w] && (tag_arr[w][req_idx] == req_tag);
      end
   end

   assign hit       = |way_hit;
   assign hit_way   = way_hit[1];
   assign hit_block = data_arr[hit_way][req_idx];

   // Prefer an empty way (way0 first); otherwise evict the least recently used one.
   always_comb begin
      if (!valid_q[req_idx][0]) begin
         victim_d = 1'b0;
      end else if (!valid_q[req_idx][1]) begin
         victim_d = 1'b1;
      end else begin
         victim_d = lru_q[req_idx];
      end
   end

   assign victim_dirty = valid_q[req_idx][victim_d] & dirty_q[req_idx][victim_d];

   always_comb begin
      state_d      = state_q;
      cpu_busywait = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               cpu_busywait = 1'b1;
               state_d      = victim_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            cpu_busywait = 1'b1;
            mem_write    = 1'b1;
            mem_addr     = {tag_arr[victim_q][req_idx_q], req_idx_q};
            mem_wdata    = data_arr[victim_q][req_idx_q];
            if (!mem_busywait) begin
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            cpu_busywait = 1'b1;
            mem_read     = 1'b1;
            mem_addr     = {req_tag_q, req_idx_q};
            if (!mem_busywait) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A pending miss in IDLE must not stall the pipeline while reset is held.
      if (reset) begin
         cpu_busywait = 1'b0;
      end
   end

   always_comb begin
      cpu_rdata = '0;
      if (!reset && state_q == IDLE && cpu_read && hit) begin
         cpu_rdata = hit_block[word_base +: 32];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         lru_q     <= '0;
         victim_q  <= 1'b0;
         req_tag_q <= '0;
         req_idx_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req) begin
            if (hit) begin
               lru_q[req_idx] <= ~hit_way;
               if (cpu_write) begin
                  dirty_q[req_idx][hit_way] <= 1'b1;
               end
            end else begin
               victim_q  <= victim_d;
               req_tag_q <= req_tag;
               req_idx_q <= req_idx;
            end
         end
         if (state_q == ALLOCATE && !mem_busywait) begin
            valid_q[req_idx_q][victim_q] <= 1'b1;
            dirty_q[req_idx_q][victim_q] <= 1'b0;
         end
      end
   end

   // Tag and data storage carry no reset; contents are qualified by valid_q.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req && hit && cpu_write) begin
         data_arr[hit_way][req_idx][word_base +: 32] <= cpu_wdata;
      end
      if (state_q == ALLOCATE && !mem_busywait) begin
         data_arr[victim_q][req_idx_q] <= mem_rdata;
         tag_arr[victim_q][req_idx_q]  <= req_tag_q;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a latency-programmable block memory model.
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_read;
   logic         cpu_write;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata;
   logic         cpu_busywait;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_busywait;

   int           checks = 0;
   int           errors = 0;
   int           lat = 5;
   int           cnt = 0;
   int           rd_count = 0;
   int           wr_count = 0;
   logic [27:0]  last_rd_addr = '0;
   logic [27:0]  last_wr_addr = '0;
   logic [127:0] last_wr_data = '0;
   logic         both_hi = 1'b0;

   int           cyc;
   logic [31:0]  rdat;
   int           rc0;
   int           wc0;

   dcache_controller #(
      .SETS(8),
      .WAYS(2),
      .BLOCK_WORDS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cpu_read(cpu_read),
      .cpu_write(cpu_write),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_busywait(cpu_busywait),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_busywait(mem_busywait)
   );

   always #5 clk = ~clk;

   // Memory block content: word i of block a is 0xA000_0000 + byte address of that word's block + i.
   function automatic logic [127:0] blk(input logic [27:0] a);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) begin
         b[32*i +: 32] = 32'hA000_0000 + {a, 4'h0} + 32'(i);
      end
      return b;
   endfunction

   assign mem_rdata    = blk(mem_addr);
   assign mem_busywait = (mem_read || mem_write) && (cnt < lat - 1);

   always @(posedge clk) begin
      if (!(mem_read || mem_write)) begin
         cnt <= 0;
      end else if (mem_busywait) begin
         cnt <= cnt + 1;
      end else begin
         cnt <= 0;
      end
      if (mem_read && !mem_busywait) begin
         rd_count     <= rd_count + 1;
         last_rd_addr <= mem_addr;
      end
      if (mem_write && !mem_busywait) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= mem_addr;
         last_wr_data <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (mem_read && mem_write) both_hi <= 1'b1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output int n, output logic [31:0] rv);
      @(negedge clk);
      cpu_read  = rd;
      cpu_write = wr;
      cpu_addr  = a;
      cpu_wdata = wd;
      #1;
      n = 1;
      while (cpu_busywait && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      rv = cpu_rdata;
      @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      cpu_read  = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = 32'h0000_0040;
      cpu_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busywait", cpu_busywait, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_rdata", cpu_rdata, 0);
      @(negedge clk);
      cpu_read = 1'b0;
      reset    = 1'b0;

      // Clean read miss, 5-cycle memory
      lat = 5;
      rc0 = rd_count; wc0 = wr_count;
      do_access(1, 0, 32'h40, 0, cyc, rdat);
      check("miss_cycles", cyc, 7);
      check("miss_rdata", rdat, 32'hA000_0040);
      check("miss_refills", rd_count - rc0, 1);
      check("miss_refill_addr", last_rd_addr, 28'h004);
      check("miss_no_wb", wr_count - wc0, 0);

      do_access(1, 0, 32'h40, 0, cyc, rdat);
      check("rehit_cycles", cyc, 1);
      check("rehit_rdata", rdat, 32'hA000_0040);
      do_access(1, 0, 32'h4C, 0, cyc, rdat);
      check("hit_word3", rdat, 32'hA000_0043);

      rc0 = rd_count;
      do_access(0, 1, 32'h44, 32'h1234_5678, cyc, rdat);
      check("wr_hit_cycles", cyc, 1);
      do_access(1, 0, 32'h44, 0, cyc, rdat);
      check("wr_readback", rdat, 32'h1234_5678);
      check("wr_hit_no_refill", rd_count - rc0, 0);

      // LRU victim with write-back in set 4
      pulse_reset();
      wc0 = wr_count;
      do_access(0, 1, 32'hC0, 32'h1111_1111, cyc, rdat);
      check("fill_t1_cycles", cyc, 7);
      do_access(0, 1, 32'h148, 32'h2222_2222, cyc, rdat);
      check("fill_t2_cycles", cyc, 7);
      check("fill_no_wb", wr_count - wc0, 0);
      do_access(1, 0, 32'hC0, 0, cyc, rdat);
      check("t1_hit", rdat, 32'h1111_1111);
      do_access(1, 0, 32'h1C4, 0, cyc, rdat);
      check("dirty_miss_cycles", cyc, 12);
      check("dirty_miss_wb_count", wr_count - wc0, 1);
      check("dirty_miss_wb_addr", last_wr_addr, 28'h014);
      check("dirty_miss_wb_data", last_wr_data,
            {32'hA000_0143, 32'h2222_2222, 32'hA000_0141, 32'hA000_0140});
      check("dirty_miss_refill_addr", last_rd_addr, 28'h01C);
      check("dirty_miss_rdata", rdat, 32'hA000_01C1);
      do_access(1, 0, 32'hC0, 0, cyc, rdat);
      check("t1_kept", rdat, 32'h1111_1111);
      check("t1_kept_cycles", cyc, 1);

      // Clean victim, zero-wait memory
      lat = 1;
      wc0 = wr_count;
      do_access(1, 0, 32'h2C0, 0, cyc, rdat);
      check("clean_fast_cycles", cyc, 3);
      check("clean_no_wb", wr_count - wc0, 0);
      check("clean_rdata", rdat, 32'hA000_02C0);

      // Reset while refilling
      lat = 5;
      @(negedge clk);
      cpu_read = 1'b1;
      cpu_addr = 32'h200;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("alloc_mem_read", mem_read, 1);
      reset = 1'b1;
      #1;
      check("rst_alloc_mem_read", mem_read, 0);
      check("rst_alloc_busywait", cpu_busywait, 0);
      @(negedge clk);
      reset    = 1'b0;
      cpu_read = 1'b0;
      lat = 1;
      do_access(1, 0, 32'h200, 0, cyc, rdat);
      check("post_rst_miss_cycles", cyc, 3);
      check("post_rst_rdata", rdat, 32'hA000_0200);
      do_access(1, 0, 32'hC0, 0, cyc, rdat);
      check("post_rst_set4_miss", cyc, 3);

      // Read and write together on a hit act as a write
      do_access(1, 1, 32'h200, 32'h5A5A_5A5A, cyc, rdat);
      check("rw_hit_cycles", cyc, 1);
      do_access(1, 0, 32'h200, 0, cyc, rdat);
      check("rw_readback", rdat, 32'h5A5A_5A5A);
      wc0 = wr_count;
      do_access(1, 0, 32'h280, 0, cyc, rdat);
      check("rw_fill_way1", cyc, 3);
      do_access(1, 0, 32'h300, 0, cyc, rdat);
      check("rw_evict_cycles", cyc, 4);
      check("rw_evict_wb_count", wr_count - wc0, 1);
      check("rw_evict_wb_addr", last_wr_addr, 28'h020);
      check("rw_evict_wb_word0", last_wr_data[31:0], 32'h5A5A_5A5A);

      check("no_read_write_overlap", both_hi, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
